// File: rtl/ifetch_pkg.sv
// Shared types and instruction field layout for the instruction fetch sequencer.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int INSTR_W = 20;

    localparam int END_BIT = 19;
    localparam int OP_MSB  = 18;
    localparam int OP_LSB  = 16;
    localparam int A_MSB   = 15;
    localparam int A_LSB   = 8;
    localparam int B_MSB   = 7;
    localparam int B_LSB   = 0;

endpackage

// File: rtl/instruction_fetch_if.sv
// Program-load, control and instruction-issue signals between the sequencer and its environment.
interface instruction_fetch_if #(
    parameter int DEPTH = 16
) ();
    import ifetch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic               load_en;
    logic [AW-1:0]      load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               start;
    logic               ready;
    logic               valid;
    logic [2:0]         opcode;
    logic [7:0]         a;
    logic [7:0]         b;
    logic [AW-1:0]      pc;
    logic               busy;
    logic               halted;

    modport master (
        output load_en, load_addr, load_data, start, ready,
        input  valid, opcode, a, b, pc, busy, halted
    );

    modport slave (
        input  load_en, load_addr, load_data, start, ready,
        output valid, opcode, a, b, pc, busy, halted
    );

endinterface

// File: rtl/instr_ram.sv
// Instruction store: one synchronous write port and one registered read port.
// A write and a read of the same address on one edge returns the new word.
module instr_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // NOTE: the storage array has no reset so it maps to RAM and keeps the program across rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_fetch.sv
// Program sequencer: steps pc through instr_ram and issues opcode/a/b under valid/ready.
// Optional: define IFETCH_WRAP_EN to wrap pc from DEPTH-1 to 0 instead of halting there.
module instruction_fetch
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input logic                clk,
    input logic                rst,
    instruction_fetch_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [AW-1:0]      r_pc;
    logic [AW-1:0]      w_pc_next;
    logic [2:0]         r_opcode;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic               r_end;
    logic               w_load_ok;
    logic               w_ram_we;
    logic               w_ram_re;
    logic [INSTR_W-1:0] w_rdata;

    assign w_load_ok = (r_state == IDLE) || (r_state == HALT);
    assign w_ram_we  = bus.load_en && w_load_ok;
    // The read is launched on the edge entering FETCH, so the word is ready when FETCH ends.
    assign w_ram_re  = (w_state_next == FETCH);

    instr_ram #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (bus.load_addr),
        .i_wdata (bus.load_data),
        .i_re    (w_ram_re),
        .i_raddr (w_pc_next),
        .o_rdata (w_rdata)
    );

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        unique case (r_state)
            IDLE, HALT: begin
                if (bus.start) begin
                    w_state_next = FETCH;
                    w_pc_next    = '0;
                end
            end
            FETCH: begin
                w_state_next = ISSUE;
            end
            ISSUE: begin
                if (bus.ready) begin
                    if (r_end) begin
                        w_state_next = HALT;
                    end else if (r_pc == AW'(DEPTH - 1)) begin
`ifdef IFETCH_WRAP_EN
                        w_state_next = FETCH;
                        w_pc_next    = '0;
`else
                        w_state_next = HALT;
`endif
                    end else begin
                        w_state_next = FETCH;
                        w_pc_next    = r_pc + AW'(1);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_opcode <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_end    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (r_state == FETCH) begin
                r_end    <= w_rdata[END_BIT];
                r_opcode <= w_rdata[OP_MSB:OP_LSB];
                r_a      <= w_rdata[A_MSB:A_LSB];
                r_b      <= w_rdata[B_MSB:B_LSB];
            end
        end
    end

    assign bus.valid  = (r_state == ISSUE);
    assign bus.busy   = (r_state == FETCH) || (r_state == ISSUE);
    assign bus.halted = (r_state == HALT);
    assign bus.opcode = r_opcode;
    assign bus.a      = r_a;
    assign bus.b      = r_b;
    assign bus.pc     = r_pc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program sequencer that feeds the CPU execute path. Holds a small writable instruction RAM, steps a program counter, and presents each decoded instruction as opcode and operands a/b under a valid/ready handshake. The execute side (control unit, ALU, result register) consumes these fields. Program loading, start, end-of-program halt, and back-pressure are all handled here.

## Interface
- DEPTH, 16, number of instruction words; power of two, at least 2
- AW, $clog2(DEPTH), PC and address width; derived, never overridden
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- load_en  input  1  write load_data into RAM at load_addr
- load_addr  input  AW  program write address
- load_data  input  20  instruction word: [19] end marker, [18:16] opcode, [15:8] a, [7:0] b
- start  input  1  begin execution from address 0
- ready  input  1  execute side accepts the presented instruction
- valid  output  1  opcode/a/b hold a valid instruction
- opcode  output  3  ALU operation select for the current instruction
- a  output  8  operand A
- b  output  8  operand B
- pc  output  AW  address of the instruction being fetched or presented
- busy  output  1  high in FETCH and ISSUE
- halted  output  1  high in HALT

## Operation
- FSM states:
  - IDLE: entered after reset.
  - FETCH: RAM read at pc; output registers load on exit.
  - ISSUE: valid=1.
  - HALT: halted=1.
- State transitions:
  - IDLE --start--> FETCH with pc=0.
  - FETCH --> ISSUE, always after 1 cycle.
  - ISSUE with valid&&ready and end marker set --> HALT.
  - ISSUE with valid&&ready, no end marker, pc<DEPTH-1 --> FETCH with pc+1.
  - ISSUE with valid&&ready, no end marker, pc==DEPTH-1 --> see Configuration.
  - ISSUE with !ready --> stays in ISSUE; opcode/a/b/pc held stable.
  - HALT --start--> FETCH with pc=0.
- Loading:
  - load_en is honoured only in IDLE and HALT; it is ignored in FETCH and ISSUE.
  - The write completes on the same edge it is sampled.
- start is ignored in FETCH and ISSUE.
- If load_en and start are both asserted in IDLE/HALT, the write and the transition both occur. The first fetch follows and sees the new data when load_addr==0.
- rst clears the FSM and all outputs. RAM contents are not cleared and survive reset.
- rst mid-program aborts immediately: valid drops the next cycle and no partial handshake completes.

## Timing
- Reset values: valid=0, opcode=0, a=0, b=0, pc=0, busy=0, halted=0; state=IDLE.
- start sampled at edge N: busy=1 from N+1 (FETCH) and valid=1 from N+2.
- Handshake occurs on the edge where valid&&ready. valid drops the following cycle (FETCH or HALT).
- Peak throughput is one instruction per 2 cycles with ready held high.
- After the end-marked instruction handshakes at edge M: halted=1 and busy=0 from M+1.
- RAM read is synchronous with a 1-cycle latency, which is covered by the FETCH state.

## Configuration
- IFETCH_WRAP_EN:
  - Defined: a handshake at pc==DEPTH-1 without an end marker wraps pc to 0 and continues in FETCH, so the program runs forever until rst or an end marker.
  - Undefined: the same condition goes to HALT, identical to an end marker.

## Structure
- Package ifetch_pkg holds:
  - state enum (IDLE, FETCH, ISSUE, HALT)
  - INSTR_W=20
  - field bit positions END_BIT, OP_MSB/OP_LSB, A_MSB/A_LSB, B_MSB/B_LSB
- Sub-module instr_ram: DEPTH x INSTR_W, one synchronous write port, one synchronous read port, no reset.

## Test plan
- Reset behaviour: assert rst for 2 cycles, then release -> all outputs 0 and state IDLE. Load addr0={0,3'b001,8'h05,8'h03}, addr1={1,3'b010,8'hF0,8'h0F}, pulse start with ready=1.
  - Required: opcode=1/a=05/b=03 valid at N+2; opcode=2/a=F0/b=0F valid at N+4; halted=1 at N+5.
- Back-pressure: hold ready=0 for 5 cycles during ISSUE -> valid, opcode, a, b, pc remain unchanged; the handshake completes on the first ready=1 edge.
- Load/start gating: assert load_en to addr0 during ISSUE -> RAM unchanged (verify by re-running). Pulse start while busy -> pc is not reset.
- Wrap, DEPTH=4, no end markers:
  - Without IFETCH_WRAP_EN: halted after pc=3 issues.
  - With it: the 5th issued instruction comes from pc=0.
- Reset mid-program: rst in ISSUE at pc=2 -> valid=0 next cycle, pc=0, IDLE. A subsequent start replays from addr0 with RAM contents intact.
